// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, the encoder error code enum and immediate range helpers.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'b00,
        ERR_UNSUPPORTED = 2'b01,
        ERR_IMM_RANGE   = 2'b10,
        ERR_MISALIGNED  = 2'b11
    } enc_err_e;

    // True when imm is representable as a 12-bit signed value (I/S formats).
    function automatic logic imm_fits_12(input logic [31:0] imm);
        return (imm[31:11] == {21{imm[11]}});
    endfunction

    // True when imm is representable as a 13-bit signed value (SB format).
    function automatic logic imm_fits_13(input logic [31:0] imm);
        return (imm[31:12] == {20{imm[12]}});
    endfunction

endpackage

// File: rtl/instruction_packer.sv
// Combinational fields-to-word packing for R/I-load/S/SB formats.
// Immediate range/alignment checks are built only with IMM_RANGE_CHECK_EN defined.
module instruction_packer
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output enc_err_e    err_code
);

`ifndef IMM_RANGE_CHECK_EN
    // Upper immediate bits are deliberately dropped when range checking is off.
    logic unused_imm_s;
    assign unused_imm_s = ^imm[31:13];
`endif

    // Select the format layout from the opcode and flag anything unencodable.
    always_comb begin
        word     = 32'h0000_0000;
        err_code = ERR_NONE;
        case (opcode)
            OP_RTYPE: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OP_LOAD: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                if (!imm_fits_12(imm)) begin
                    err_code = ERR_IMM_RANGE;
                end else begin
                    err_code = ERR_NONE;
                end
`endif
            end
            OP_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef IMM_RANGE_CHECK_EN
                if (!imm_fits_12(imm)) begin
                    err_code = ERR_IMM_RANGE;
                end else begin
                    err_code = ERR_NONE;
                end
`endif
            end
            OP_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef IMM_RANGE_CHECK_EN
                // Range takes priority over misalignment when both are wrong.
                if (!imm_fits_13(imm)) begin
                    err_code = ERR_IMM_RANGE;
                end else if (imm[0]) begin
                    err_code = ERR_MISALIGNED;
                end else begin
                    err_code = ERR_NONE;
                end
`endif
            end
            default: begin
                word     = 32'h0000_0000;
                err_code = ERR_UNSUPPORTED;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes field sets into RV32I words for instruction-memory preload, with an auto-incrementing
// word address, valid/ready on both sides and a sticky wrap flag. Optional macro: IMM_RANGE_CHECK_EN.
module instruction_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              wrapped
);

    logic [31:0]       word_s;
    enc_err_e          pack_err_s;
    logic              accept_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              wrap_s;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q,  out_inst_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              started_q,   started_d;
    logic              wrapped_q,   wrapped_d;
    logic              err_valid_q, err_valid_d;
    enc_err_e          err_code_q,  err_code_d;

    instruction_packer u_packer (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .word     (word_s),
        .err_code (pack_err_s)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // out_addr_q doubles as the address counter; the first word after reset lands on BASE_ADDR.
    assign next_addr_s = started_q ? (out_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1}) : BASE_ADDR;
    assign wrap_s      = started_q && (out_addr_q == {ADDR_W{1'b1}});

    // Next-state for the output register, address counter, wrap flag and error pulse.
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        started_d   = started_q;
        wrapped_d   = wrapped_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;
        if (accept_s && (pack_err_s == ERR_NONE)) begin
            out_valid_d = 1'b1;
            out_inst_d  = word_s;
            out_addr_d  = next_addr_s;
            started_d   = 1'b1;
            wrapped_d   = wrapped_q || wrap_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s && (pack_err_s != ERR_NONE)) begin
            err_valid_d = 1'b1;
            err_code_d  = pack_err_s;
        end else begin
            err_valid_d = 1'b0;
            err_code_d  = ERR_NONE;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0000_0000;
            out_addr_q  <= BASE_ADDR;
            started_q   <= 1'b0;
            wrapped_q   <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            started_q   <= started_d;
            wrapped_q   <= wrapped_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench: two encoders (ADDR_W=2/BASE 0 and ADDR_W=3/BASE 5) share one stimulus stream.
module tb_instruction_encoder;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        a_in_ready, a_out_valid, a_err_valid, a_wrapped;
    logic [31:0] a_out_inst;
    logic [1:0]  a_out_addr, a_err_code;
    logic        b_in_ready, b_out_valid, b_err_valid, b_wrapped;
    logic [31:0] b_out_inst;
    logic [2:0]  b_out_addr;
    logic [1:0]  b_err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(a_out_valid), .out_ready(out_ready), .out_inst(a_out_inst),
        .out_addr(a_out_addr), .err_valid(a_err_valid), .err_code(a_err_code), .wrapped(a_wrapped)
    );

    instruction_encoder #(.ADDR_W(3), .BASE_ADDR(3'd5)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(b_out_valid), .out_ready(out_ready), .out_inst(b_out_inst),
        .out_addr(b_out_addr), .err_valid(b_err_valid), .err_code(b_err_code), .wrapped(b_wrapped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] im);
        opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic check_word(input string tag, input logic [31:0] inst,
                              input logic [1:0] addr_a, input logic [2:0] addr_b);
        check({tag, ".a_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, ".b_valid"}, 32'(b_out_valid), 32'd1);
        check({tag, ".a_inst"}, a_out_inst, inst);
        check({tag, ".b_inst"}, b_out_inst, inst);
        check({tag, ".a_addr"}, 32'(a_out_addr), 32'(addr_a));
        check({tag, ".b_addr"}, 32'(b_out_addr), 32'(addr_b));
        check({tag, ".a_err"}, 32'(a_err_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_fields(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #12;
        check("rst.a_valid", 32'(a_out_valid), 32'd0);
        check("rst.a_inst", a_out_inst, 32'd0);
        check("rst.a_addr", 32'(a_out_addr), 32'd0);
        check("rst.b_addr", 32'(b_out_addr), 32'd5);
        check("rst.err", 32'({a_err_valid, a_err_code}), 32'd0);
        check("rst.wrapped", 32'({a_wrapped, b_wrapped}), 32'd0);
        check("rst.in_ready", 32'(a_in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back encodings with out_ready held high
        set_fields(OP_LOAD, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'd8);
        in_valid = 1'b1;
        tick();
        check_word("load", 32'h0081_2283, 2'd0, 3'd5);
        check("load.in_ready", 32'(a_in_ready), 32'd1);
        set_fields(OP_RTYPE, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        check_word("add", 32'h0020_81B3, 2'd1, 3'd6);
        set_fields(OP_STORE, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, -32'sd4);
        tick();
        check_word("store", 32'hFE51_2E23, 2'd2, 3'd7);
        check("store.b_wrapped", 32'(b_wrapped), 32'd0);
        set_fields(OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
        tick();
        check_word("beq", 32'hFE20_8CE3, 2'd3, 3'd0);
        check("beq.a_wrapped", 32'(a_wrapped), 32'd0);
        check("beq.b_wrapped", 32'(b_wrapped), 32'd1);
        set_fields(OP_LOAD, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        tick();
        check_word("wrap5", 32'h0000_0083, 2'd0, 3'd1);
        check("wrap5.a_wrapped", 32'(a_wrapped), 32'd1);

        // Unsupported opcode while the previous word drains
        set_fields(7'b0010111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        check("unsup.a_valid", 32'(a_out_valid), 32'd0);
        check("unsup.err_valid", 32'(a_err_valid), 32'd1);
        check("unsup.err_code", 32'(a_err_code), 32'd1);
        check("unsup.b_err_code", 32'(b_err_code), 32'd1);
        check("unsup.a_addr", 32'(a_out_addr), 32'd0);
        check("unsup.a_inst", a_out_inst, 32'h0000_0083);
        tick();
        check("unsup.pulse", 32'(a_err_valid), 32'd0);

        // Backpressure: three stalled cycles, then drain and accept together
        out_ready = 1'b0;
        set_fields(OP_RTYPE, 3'b000, 7'h20, 5'd6, 5'd4, 5'd3, 32'd0);
        in_valid = 1'b1;
        tick();
        check_word("bp.w1", 32'h4032_0333, 2'd1, 3'd2);
        set_fields(OP_LOAD, 3'b010, 7'd0, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            check("bp.in_ready", 32'(a_in_ready), 32'd0);
            check("bp.hold_inst", a_out_inst, 32'h4032_0333);
            check("bp.hold_addr", 32'(a_out_addr), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(a_in_ready), 32'd1);
        tick();
        check_word("bp.w2", 32'hFFF4_2383, 2'd2, 3'd3);
        in_valid = 1'b0;
        tick();
        check("bp.drained", 32'(a_out_valid), 32'd0);

`ifdef IMM_RANGE_CHECK_EN
        set_fields(OP_LOAD, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'd2048);
        in_valid = 1'b1;
        tick();
        check("rng.i_err", 32'({a_err_valid, a_err_code}), 32'b110);
        check("rng.i_valid", 32'(a_out_valid), 32'd0);
        check("rng.i_addr", 32'(a_out_addr), 32'd2);
        set_fields(OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        tick();
        check("rng.sb_misalign", 32'({a_err_valid, a_err_code}), 32'b111);
        set_fields(OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'h0000_1001);
        tick();
        check("rng.sb_both", 32'({a_err_valid, a_err_code}), 32'b110);
        in_valid = 1'b0;
        tick();
        check("rng.no_emit", 32'({a_out_valid, a_out_addr}), 32'b010);
`else
        set_fields(OP_LOAD, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'd2048);
        in_valid = 1'b1;
        tick();
        check_word("trunc.i", 32'h8001_2283, 2'd3, 3'd4);
        set_fields(OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        tick();
        check_word("trunc.sb", 32'h0020_8363, 2'd0, 3'd5);
        in_valid = 1'b0;
        tick();
`endif

        // Reset while a word is held
        out_ready = 1'b0;
        set_fields(OP_LOAD, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'd8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid.held", 32'(a_out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid.a_valid", 32'(a_out_valid), 32'd0);
        check("mid.b_valid", 32'(b_out_valid), 32'd0);
        check("mid.addr", 32'({a_out_addr, b_out_addr}), 32'({2'd0, 3'd5}));
        check("mid.wrapped", 32'({a_wrapped, b_wrapped}), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        set_fields(OP_RTYPE, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_word("post_rst", 32'h0020_81B3, 2'd0, 3'd5);
        check("post_rst.wrapped", 32'({a_wrapped, b_wrapped}), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
